// File: rtl/psola_pkg.sv
// Shared constants, sample typedefs and playback FSM states for the PSOLA output path.
package psola_pkg;

  localparam int MAX_EXTENDED = 2200;
  localparam int FRAC_BITS    = 10;
  localparam int BRAM_LAT     = 2;

  typedef logic signed [31:0] fixed_t;
  typedef logic signed [15:0] pcm_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READY,
    ST_FETCH,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/fixed_to_pcm.sv
// Combinational round-half-up and saturate from signed 22.10 to signed 16-bit PCM.
module fixed_to_pcm
  import psola_pkg::*;
#(
  parameter int FRAC_BITS = psola_pkg::FRAC_BITS
) (
  input  fixed_t fixed_in,
  output pcm_t   pcm_out
);

  localparam int QW = 33 - FRAC_BITS;
  localparam logic signed [32:0]   HALF    = 33'sd1 <<< (FRAC_BITS - 1);
  localparam logic signed [QW-1:0] PCM_MAX = QW'(32767);
  localparam logic signed [QW-1:0] PCM_MIN = QW'(-32768);

  logic signed [32:0]   biased;
  logic signed [QW-1:0] whole;

  // One guard bit keeps the rounding bias from wrapping near full scale.
  always_comb begin
    biased = 33'(fixed_in) + HALF;
    whole  = biased[32:FRAC_BITS];
    if (whole > PCM_MAX) begin
      pcm_out = 16'sh7fff;
    end else if (whole < PCM_MIN) begin
      pcm_out = 16'sh8000;
    end else begin
      pcm_out = whole[15:0];
    end
  end

endmodule

// File: rtl/pipeline.sv
// Generic delay line: data_out is data_in delayed by STAGES clock cycles.
module pipeline #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] stage [STAGES];

  // NOTE: this short delay line is reset so an abandoned fetch cannot leave a stale strobe behind; bulk RAMs are never reset this way.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= data_in;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign data_out = stage[STAGES-1];

endmodule

// File: rtl/psola_playback.sv
// Drains the PSOLA overlap-add buffer one sample per audio tick, converting 22.10 to PCM.
// Define PSOLA_PLAYBACK_CLEAR_EN to zero each BRAM word after it has been played.
module psola_playback
  import psola_pkg::*;
#(
  parameter  int MAX_EXTENDED = psola_pkg::MAX_EXTENDED,
  parameter  int FRAC_BITS    = psola_pkg::FRAC_BITS,
  localparam int ADDR_BITS    = $clog2(MAX_EXTENDED)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [11:0]          window_len_in,
  input  logic                 window_len_valid_in,
  input  logic                 sample_tick_in,
  output logic [ADDR_BITS-1:0] read_addr,
  input  logic [31:0]          read_val,
  output logic [ADDR_BITS-1:0] clear_addr,
  output logic                 clear_en,
  output logic [15:0]          sample_out,
  output logic                 sample_valid_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 underrun_out
);

  localparam int LEN_BITS = $clog2(MAX_EXTENDED + 1);

  state_t               state, state_d;
  logic [LEN_BITS-1:0]  len, len_d, idx, idx_d, idx_inc;
  logic [LEN_BITS-1:0]  pend_len, pend_len_d, len_clamped, next_len;
  logic                 pend_valid, pend_valid_d, next_valid;
  logic                 issue, issue_d, fetch_due;
  logic [ADDR_BITS-1:0] read_addr_d, clear_addr_d;
  logic                 clear_en_d, sample_valid_d, done_d, underrun_d;
  pcm_t                 pcm, sample_d;

  fixed_to_pcm #(.FRAC_BITS(FRAC_BITS)) u_conv (
    .fixed_in (read_val),
    .pcm_out  (pcm)
  );

  // Issue strobe delayed so the FSM enters EMIT exactly when read_val is valid.
  pipeline #(.WIDTH(1), .STAGES(BRAM_LAT - 1)) u_align (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  (issue),
    .data_out (fetch_due)
  );

  assign idx_inc  = idx + 1'b1;
  assign busy_out = (state != ST_IDLE);

  // NOTE: every variable gets a default before the case so no path leaves a latch.
  always_comb begin
    state_d        = state;
    len_d          = len;
    idx_d          = idx;
    pend_valid_d   = pend_valid;
    pend_len_d     = pend_len;
    read_addr_d    = read_addr;
    issue_d        = 1'b0;
    sample_d       = '0;
    sample_valid_d = 1'b0;
    done_d         = 1'b0;
    underrun_d     = 1'b0;
    clear_en_d     = 1'b0;
    clear_addr_d   = '0;
    next_valid     = 1'b0;
    next_len       = '0;

    if (int'(window_len_in) > MAX_EXTENDED) len_clamped = LEN_BITS'(MAX_EXTENDED);
    else                                    len_clamped = LEN_BITS'(window_len_in);

    if (window_len_valid_in && state != ST_IDLE) begin
      pend_valid_d = 1'b1;
      pend_len_d   = len_clamped;
    end

    case (state)
      ST_IDLE: begin
        if (sample_tick_in) begin
          sample_valid_d = 1'b1;
          underrun_d     = 1'b1;
        end
        if (window_len_valid_in) begin
          if (len_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            len_d   = len_clamped;
            idx_d   = '0;
            state_d = ST_READY;
          end
        end
      end
      ST_READY: begin
        if (sample_tick_in) begin
          read_addr_d = idx[ADDR_BITS-1:0];
          issue_d     = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fetch_due) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        sample_d       = pcm;
        sample_valid_d = 1'b1;
`ifdef PSOLA_PLAYBACK_CLEAR_EN
        clear_en_d     = 1'b1;
        clear_addr_d   = read_addr;
`else
        clear_en_d     = 1'b0;
        clear_addr_d   = '0;
`endif
        idx_d = idx_inc;
        if (idx_inc == len) begin
          done_d = 1'b1;
          // A strobe landing on the final sample is newer than anything pending.
          next_valid   = window_len_valid_in || pend_valid;
          next_len     = window_len_valid_in ? len_clamped : pend_len;
          pend_valid_d = 1'b0;
          idx_d        = '0;
          if (next_valid && next_len != '0) begin
            len_d   = next_len;
            state_d = ST_READY;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_READY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= ST_IDLE;
      len              <= '0;
      idx              <= '0;
      pend_valid       <= 1'b0;
      pend_len         <= '0;
      issue            <= 1'b0;
      read_addr        <= '0;
      clear_addr       <= '0;
      clear_en         <= 1'b0;
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      done_out         <= 1'b0;
      underrun_out     <= 1'b0;
    end else begin
      state            <= state_d;
      len              <= len_d;
      idx              <= idx_d;
      pend_valid       <= pend_valid_d;
      pend_len         <= pend_len_d;
      issue            <= issue_d;
      read_addr        <= read_addr_d;
      clear_addr       <= clear_addr_d;
      clear_en         <= clear_en_d;
      sample_out       <= sample_d;
      sample_valid_out <= sample_valid_d;
      done_out         <= done_d;
      underrun_out     <= underrun_d;
    end
  end

endmodule

// File: tb/tb_psola_playback.sv
// Randomized bench for psola_playback against a per-tick behavioural model of the playback rules.
module tb_psola_playback;
  import psola_pkg::*;

  localparam int DEPTH = MAX_EXTENDED;
  localparam int AW    = $clog2(DEPTH);

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [11:0]   window_len_in = '0;
  logic          window_len_valid_in = 1'b0;
  logic          sample_tick_in = 1'b0;
  logic [AW-1:0] read_addr;
  logic [31:0]   read_val;
  logic [AW-1:0] clear_addr;
  logic          clear_en;
  logic [15:0]   sample_out;
  logic          sample_valid_out, busy_out, done_out, underrun_out;

  always #5 clk_in = ~clk_in;

  psola_playback dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .window_len_in       (window_len_in),
    .window_len_valid_in (window_len_valid_in),
    .sample_tick_in      (sample_tick_in),
    .read_addr           (read_addr),
    .read_val            (read_val),
    .clear_addr          (clear_addr),
    .clear_en            (clear_en),
    .sample_out          (sample_out),
    .sample_valid_out    (sample_valid_out),
    .busy_out            (busy_out),
    .done_out            (done_out),
    .underrun_out        (underrun_out)
  );

  // Processed-signal BRAM: two-cycle read latency, clear writes, bulk load from ref_mem.
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] rd_q1;
  logic        load_req = 1'b0;
  int          cyc = 0;

  always @(posedge clk_in) begin
    cyc     <= cyc + 1;
    rd_q1   <= mem[read_addr];
    read_val <= rd_q1;
    if (clear_en) mem[clear_addr] <= 32'h0;
    if (load_req) for (int k = 0; k < DEPTH; k++) mem[k] <= ref_mem[k];
  end

  int n_cmp = 0, n_bad = 0, n_valid = 0, n_done = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model state: expected events keyed by the cycle they must appear in.
  logic [15:0] exp_smp  [int];
  bit          exp_und  [int];
  bit          exp_done [int];
  int          exp_clr  [int];
  int exp_busy_now = 0, exp_raddr_now = 0;
  int m_active = 0, m_len = 0, m_idx = 0, m_pend_v = 0, m_pend_len = 0, m_raddr = 0;
  int m_busy_until = -100, m_emit_at = -100;

  function automatic logic [15:0] pcm_of(logic [31:0] w);
    real r;
    r = $floor(real'(int'($signed(w))) / 1024.0 + 0.5);
    if (r > 32767.0)  r = 32767.0;
    if (r < -32768.0) r = -32768.0;
    return 16'($rtoi(r));
  endfunction

  function automatic logic [31:0] rand_word();
    int v;
    case ($urandom_range(0, 3))
      0:       v = int'($urandom);
      1:       v = (int'($urandom_range(0, 80)) - 40) * 1024 + 512;
      default: v = (int'($urandom_range(0, 80000)) - 40000) * 1024 + int'($urandom_range(0, 1023));
    endcase
    return 32'(v);
  endfunction

  task automatic model(int c, bit tick, bit stb, logic [11:0] len);
    int  clamp;
    bit  stb_used;
    clamp    = (int'(len) > DEPTH) ? DEPTH : int'(len);
    stb_used = 1'b0;
    if (c == m_emit_at) begin
      exp_smp[c+1] = pcm_of(ref_mem[m_idx]);
`ifdef PSOLA_PLAYBACK_CLEAR_EN
      exp_clr[c+1] = m_idx;
      ref_mem[m_idx] = 32'h0;
`endif
      m_idx++;
      if (m_idx == m_len) begin
        exp_done[c+1] = 1'b1;
        if (stb) begin
          m_pend_v = 1; m_pend_len = clamp; stb_used = 1'b1;
        end
        if (m_pend_v != 0 && m_pend_len > 0) begin
          m_len = m_pend_len; m_idx = 0;
        end else begin
          m_active = 0;
        end
        m_pend_v = 0;
      end
    end
    if (tick && c > m_busy_until) begin
      if (m_active == 0) begin
        exp_smp[c+1] = 16'h0;
        exp_und[c+1] = 1'b1;
      end else begin
        m_raddr      = m_idx;
        m_busy_until = c + 3;
        m_emit_at    = c + 3;
      end
    end
    if (stb && !stb_used) begin
      if (m_active == 0) begin
        if (clamp == 0) exp_done[c+1] = 1'b1;
        else begin
          m_active = 1; m_len = clamp; m_idx = 0;
        end
      end else begin
        m_pend_v = 1; m_pend_len = clamp;
      end
    end
    exp_busy_now  = m_active;
    exp_raddr_now = m_raddr;
  endtask

  task automatic compare_cycle();
    int c;
    c = cyc;
    n_valid += int'(sample_valid_out);
    n_done  += int'(done_out);
    check("busy", 32'(busy_out), 32'(exp_busy_now));
    check("read_addr", 32'(read_addr), 32'(exp_raddr_now));
    check("sample_valid", 32'(sample_valid_out), 32'(exp_smp.exists(c)));
    if (exp_smp.exists(c) && sample_valid_out) check("sample", 32'(sample_out), 32'(exp_smp[c]));
    check("underrun", 32'(underrun_out), 32'(exp_und.exists(c)));
    check("done", 32'(done_out), 32'(exp_done.exists(c)));
    check("clear_en", 32'(clear_en), 32'(exp_clr.exists(c)));
    if (exp_clr.exists(c)) check("clear_addr", 32'(clear_addr), 32'(exp_clr[c]));
  endtask

  task automatic step(bit tick, bit stb, logic [11:0] len);
    @(negedge clk_in);
    compare_cycle();
    sample_tick_in      = tick;
    window_len_valid_in = stb;
    window_len_in       = len;
    model(cyc, tick, stb, len);
  endtask

  task automatic commit_mem();
    load_req = 1'b1;
    step(0, 0, 12'd0);
    load_req = 1'b0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = rand_word();
  endtask

  // Ticks only while a window is loaded; stops once the model's last sample has gone out.
  task automatic run_ticks(int gmin, int gmax, int max_cycles);
    int  gap;
    bit  finished;
    gap = 0;
    finished = 1'b0;
    for (int i = 0; i < max_cycles && !finished; i++) begin
      if (m_active == 0 && cyc > m_emit_at) finished = 1'b1;
      else begin
        if (gap <= 0 && m_active != 0) begin
          step(1, 0, 12'd0);
          gap = int'($urandom_range(gmin, gmax)) - 1;
        end else begin
          step(0, 0, 12'd0);
          gap--;
        end
      end
    end
    check("window_timeout", 32'(m_active), 32'd0);
    repeat (6) step(0, 0, 12'd0);
  endtask

  task automatic apply_reset(bit mid_run);
    step(0, 0, 12'd0);
    #2 rst_in = 1'b0;
    #1;
    check(mid_run ? "rst_mid_valid" : "rst_valid", 32'(sample_valid_out), 32'd0);
    check("rst_sample", 32'(sample_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_done_underrun", 32'({done_out, underrun_out}), 32'd0);
    check("rst_clear", 32'({clear_en, clear_addr}), 32'd0);
    check("rst_read_addr", 32'(read_addr), 32'd0);
    exp_smp.delete(); exp_und.delete(); exp_done.delete(); exp_clr.delete();
    m_active = 0; m_len = 0; m_idx = 0; m_pend_v = 0; m_pend_len = 0; m_raddr = 0;
    m_busy_until = -100; m_emit_at = -100;
    exp_busy_now = 0; exp_raddr_now = 0;
    repeat (3) step(0, 0, 12'd0);
    rst_in = 1'b1;
  endtask

  initial begin
    int v0, d0;
    rst_in = 1'b1;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'h0;
    #1 apply_reset(1'b0);
    commit_mem();

    // Directed window: 1, -1, 1, 32767.
    ref_mem[0] = 32'h0000_0400; ref_mem[1] = 32'hFFFF_FC00;
    ref_mem[2] = 32'h0000_0200; ref_mem[3] = 32'h7FFF_FFFF;
    commit_mem();
    d0 = n_done;
    step(0, 1, 12'd4);
    run_ticks(10, 10, 200);
    check("directed_done_count", 32'(n_done - d0), 32'd1);

    // Tick with nothing loaded.
    step(1, 0, 12'd0);
    repeat (4) step(0, 0, 12'd0);

    // Oversized window clamps to full depth.
    fill_random();
    commit_mem();
    v0 = n_valid;
    step(0, 1, 12'd3000);
    run_ticks(4, 6, 20000);
    check("clamp_count", 32'(n_valid - v0), 32'(DEPTH));
    check("clamp_last_addr", 32'(read_addr), 32'(DEPTH - 1));

    // Pending window strobed during playback (lands in the EMIT cycle).
    fill_random();
    commit_mem();
    d0 = n_done; v0 = n_valid;
    step(0, 1, 12'd2);
    step(1, 0, 12'd0);
    step(0, 0, 12'd0);
    step(0, 0, 12'd0);
    step(0, 1, 12'd5);
    run_ticks(4, 7, 200);
    check("pending_done_count", 32'(n_done - d0), 32'd2);
    check("pending_sample_count", 32'(n_valid - v0), 32'd7);

    // Ticks two cycles apart: every second one falls in FETCH/EMIT.
    fill_random();
    commit_mem();
    step(0, 1, 12'd6);
    run_ticks(2, 2, 200);

    // Random mix of ticks, strobes (including zero length) and idle underruns.
    for (int b = 0; b < 4; b++) begin
      fill_random();
      commit_mem();
      for (int i = 0; i < 600; i++)
        step($urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0, 12'($urandom_range(0, 8)));
      run_ticks(4, 6, 400);
    end

    // Reset while sample 1 of a 4-sample window is in flight.
    fill_random();
    commit_mem();
    step(0, 1, 12'd4);
    step(1, 0, 12'd0);
    repeat (5) step(0, 0, 12'd0);
    step(1, 0, 12'd0);
    step(0, 0, 12'd0);
    apply_reset(1'b1);
    step(1, 0, 12'd0);
    repeat (4) step(0, 0, 12'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/psola_playback.md
Name: psola_playback

Overview:
- Drains the PSOLA overlap-add buffer after `psola` reports a finished window.
- Reads the 22.10 fixed-point accumulated samples from the processed-signal BRAM, one per audio-rate tick, and rounds/saturates each to 16-bit signed PCM for the output path.
- Writes zero back behind itself (clear-after-read), so the next `psola` pass accumulates from a clean buffer.
- Sits between the processed-signal BRAM read port and the audio output serializer.

Parameters:
- MAX_EXTENDED, 2200, depth of the processed-signal BRAM in samples.
- FRAC_BITS, 10, fractional bits of the BRAM word.
- ADDR_BITS, $clog2(MAX_EXTENDED), BRAM address width (localparam).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- window_len_in  input  12  number of valid samples in the buffer
- window_len_valid_in  input  1  one-cycle strobe qualifying window_len_in
- sample_tick_in  input  1  one-cycle audio-rate request for the next sample
- read_addr  output  ADDR_BITS  BRAM read address
- read_val  input  32  BRAM data for read_addr of exactly 2 cycles earlier; signed 22.10
- clear_addr  output  ADDR_BITS  BRAM write address for zeroing
- clear_en  output  1  BRAM write enable; write data is 0
- sample_out  output  16  signed PCM sample
- sample_valid_out  output  1  one-cycle strobe qualifying sample_out
- busy_out  output  1  high while a window is being played
- done_out  output  1  one-cycle pulse when the last sample of a window is emitted
- underrun_out  output  1  one-cycle pulse when a tick arrives with nothing to play

Behaviour:
- Reset (rst_in low, asynchronous):
  - All outputs 0; FSM in IDLE.
  - idx=0, len=0, pending flag clear.
- FSM states: IDLE, READY, FETCH, EMIT.
- Length capture: window_len_valid_in latches min(window_len_in, MAX_EXTENDED).
  - In IDLE it loads len directly, sets idx=0 and moves to READY (or pulses done_out and stays IDLE if the length is 0).
  - In any other state it goes into a one-deep pending register; a second strobe overwrites the pending value.
- READY: busy_out=1, waiting for sample_tick_in.
- Tick at cycle T in READY:
  - T+1: read_addr=idx; enter FETCH.
  - T+3: read_val is valid and is captured.
  - T+4: sample_out and a one-cycle sample_valid_out pulse (EMIT).
- Conversion:
  - Shift right arithmetically by FRAC_BITS with round-half-up (add 1<<(FRAC_BITS-1) before the shift).
  - Saturate to [-32768, 32767].
- Clear-after-read: in the EMIT cycle, clear_en=1 and clear_addr=the address just read.
- After EMIT:
  - idx increments.
  - If idx==len: pulse done_out with the last sample_valid_out. If pending is set, load it and go to READY with no gap; otherwise go IDLE with busy_out=0.
  - Otherwise return to READY.
- Ticks arriving in FETCH/EMIT are ignored (no queue). Minimum tick spacing is 4 cycles.
- Tick in IDLE: next cycle sample_out=0, sample_valid_out=1, underrun_out=1; no BRAM access.
- A window_len_valid_in in the same cycle as a tick in IDLE: the length is loaded and the tick is treated as an underrun.
- Reset mid-window: abandons the window immediately; the buffer is not cleared further.

Optional Feature:
- PSOLA_PLAYBACK_CLEAR_EN
  - Defined: clear-after-read as described.
  - Undefined: clear_en is held 0 and clear_addr 0. Buffer zeroing is then the writer's responsibility.
  - Sample timing is identical in both builds.

Decomposition:
- Shared package `psola_pkg`:
  - MAX_EXTENDED, FRAC_BITS, BRAM read latency (2).
  - The 22.10 sample typedef and the 16-bit PCM typedef.
  - The FSM state enum.
- One sub-module: `fixed_to_pcm`, a combinational round-and-saturate from 22.10 to signed 16.
- Read-latency alignment reuses the existing `pipeline` block.

Test Plan:
- window_len 4, BRAM[0..3]={0x400, 0xFFFFFC00, 0x0200, 0x7FFFFFFF}, ticks every 10 cycles:
  - sample_out 1, -1, 1, 32767, each 4 cycles after its tick.
  - done_out with the 4th sample.
  - clear_en at addresses 0..3.
- Tick with no window loaded → sample_out 0, underrun_out pulse one cycle later, read_addr unchanged, clear_en never asserted.
- window_len 3000 → clamped to 2200; exactly 2200 samples emitted, last read_addr 2199, then busy_out=0.
- Second window_len 5 strobed during playback of a len-2 window → after 2 samples, 5 more with no IDLE cycle; done_out pulses twice total.
- Ticks 2 cycles apart → every second tick ignored; idx advances once per accepted tick.
- rst_in low at sample 1 of a 4-sample window → outputs 0 asynchronously; after release a tick gives underrun; with PSOLA_PLAYBACK_CLEAR_EN undefined, clear_en stays 0 throughout.
